// File: rtl/rv32i_exec_unit.sv
// Registered RV32I execute stage: decode/control, 10-op ALU, PC-relative adders.
// Optional macro EXEC_ILLEGAL_DET_EN registers an illegal-instruction flag for undecodable words.

module rv32i_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] pc_imm,
   output logic [XLEN-1:0] jump_target,
   output logic [3:0]      alu_sel,
   output logic            reg_we,
   output logic            mem_we,
   output logic            mem_re,
   output logic [1:0]      mem_size,
   output logic            load_unsigned,
   output logic [2:0]      wb_sel,
   output logic [1:0]      pc_sel,
   output logic            illegal
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Register-number fields are consumed by the register file, not here.
   logic unused_fields;
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   alu_op_e   dec_alu_sel;
   logic      dec_reg_we;
   logic      dec_mem_we;
   logic      dec_mem_re;
   logic [1:0] dec_mem_size;
   logic      dec_load_unsigned;
   logic [2:0] dec_wb_sel;
   logic [1:0] dec_pc_sel;
   logic      dec_nop;
   logic      branch_taken;
   logic      use_rs2;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_out;

   assign use_rs2 = (opcode == OP_R) || (opcode == OP_BRANCH);
   assign op_b    = use_rs2 ? rs2_data : imm;

   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:  branch_taken = (rs1_data == rs2_data);
         3'b001:  branch_taken = (rs1_data != rs2_data);
         3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  branch_taken = (rs1_data <  rs2_data);
         3'b111:  branch_taken = (rs1_data >= rs2_data);
         default: branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      dec_alu_sel       = ALU_ADD;
      dec_reg_we        = 1'b0;
      dec_mem_we        = 1'b0;
      dec_mem_re        = 1'b0;
      dec_mem_size      = 2'd0;
      dec_load_unsigned = 1'b0;
      dec_wb_sel        = 3'd0;
      dec_pc_sel        = 2'd0;
      dec_nop           = 1'b0;
      case (opcode)
         OP_R: begin
            dec_reg_we = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'b000:  dec_alu_sel = ALU_ADD;
                  3'b001:  dec_alu_sel = ALU_SLL;
                  3'b010:  dec_alu_sel = ALU_SLT;
                  3'b011:  dec_alu_sel = ALU_SLTU;
                  3'b100:  dec_alu_sel = ALU_XOR;
                  3'b101:  dec_alu_sel = ALU_SRL;
                  3'b110:  dec_alu_sel = ALU_OR;
                  default: dec_alu_sel = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec_alu_sel = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec_alu_sel = ALU_SRA;
            end else begin
               dec_nop = 1'b1;
            end
         end
         OP_IMM: begin
            dec_reg_we = 1'b1;
            case (funct3)
               3'b000: dec_alu_sel = ALU_ADD;
               3'b010: dec_alu_sel = ALU_SLT;
               3'b011: dec_alu_sel = ALU_SLTU;
               3'b100: dec_alu_sel = ALU_XOR;
               3'b110: dec_alu_sel = ALU_OR;
               3'b111: dec_alu_sel = ALU_AND;
               3'b001: begin
                  dec_alu_sel = ALU_SLL;
                  dec_nop     = (funct7 != F7_BASE);
               end
               default: begin
                  dec_alu_sel = instr[30] ? ALU_SRA : ALU_SRL;
                  dec_nop     = (funct7 != F7_BASE) && (funct7 != F7_ALT);
               end
            endcase
         end
         OP_LOAD: begin
            dec_mem_re        = 1'b1;
            dec_reg_we        = 1'b1;
            dec_wb_sel        = 3'd1;
            dec_mem_size      = funct3[1:0];
            dec_load_unsigned = funct3[2];
            dec_nop           = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
         end
         OP_STORE: begin
            dec_mem_we   = 1'b1;
            dec_mem_size = funct3[1:0];
            dec_nop      = funct3[2] || (funct3[1:0] == 2'b11);
         end
         OP_LUI: begin
            dec_reg_we = 1'b1;
            dec_wb_sel = 3'd4;
         end
         OP_AUIPC: begin
            dec_reg_we = 1'b1;
            dec_wb_sel = 3'd3;
         end
         OP_JAL: begin
            dec_reg_we = 1'b1;
            dec_wb_sel = 3'd2;
            dec_pc_sel = 2'd1;
         end
         OP_JALR: begin
            dec_reg_we = 1'b1;
            dec_wb_sel = 3'd2;
            dec_pc_sel = 2'd2;
            dec_nop    = (funct3 != 3'b000);
         end
         OP_BRANCH: begin
            dec_alu_sel = ALU_SUB;
            dec_pc_sel  = branch_taken ? 2'd1 : 2'd0;
            dec_nop     = (funct3[2:1] == 2'b01);
         end
         default: dec_nop = 1'b1;
      endcase
      // Any undecodable word collapses to a harmless NOP.
      if (dec_nop) begin
         dec_alu_sel       = ALU_ADD;
         dec_reg_we        = 1'b0;
         dec_mem_we        = 1'b0;
         dec_mem_re        = 1'b0;
         dec_mem_size      = 2'd0;
         dec_load_unsigned = 1'b0;
         dec_wb_sel        = 3'd0;
         dec_pc_sel        = 2'd0;
      end
   end

   always_comb begin
      alu_out = '0;
      case (dec_alu_sel)
         ALU_ADD:  alu_out = rs1_data + op_b;
         ALU_SUB:  alu_out = rs1_data - op_b;
         ALU_SLL:  alu_out = rs1_data << op_b[4:0];
         ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
         ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
         ALU_XOR:  alu_out = rs1_data ^ op_b;
         ALU_SRL:  alu_out = rs1_data >> op_b[4:0];
         ALU_SRA:  alu_out = XLEN'($signed(rs1_data) >>> op_b[4:0]);
         ALU_OR:   alu_out = rs1_data | op_b;
         ALU_AND:  alu_out = rs1_data & op_b;
         default:  alu_out = '0;
      endcase
   end

   // Everything except out_valid holds while no instruction is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         alu_result    <= '0;
         pc_imm        <= '0;
         jump_target   <= '0;
         alu_sel       <= 4'd0;
         reg_we        <= 1'b0;
         mem_we        <= 1'b0;
         mem_re        <= 1'b0;
         mem_size      <= 2'd0;
         load_unsigned <= 1'b0;
         wb_sel        <= 3'd0;
         pc_sel        <= 2'd0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            alu_result    <= alu_out;
            pc_imm        <= pc + imm;
            jump_target   <= (rs1_data + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
            alu_sel       <= dec_alu_sel;
            reg_we        <= dec_reg_we;
            mem_we        <= dec_mem_we;
            mem_re        <= dec_mem_re;
            mem_size      <= dec_mem_size;
            load_unsigned <= dec_load_unsigned;
            wb_sel        <= dec_wb_sel;
            pc_sel        <= dec_pc_sel;
         end
      end
   end

`ifdef EXEC_ILLEGAL_DET_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal <= 1'b0;
      end else if (in_valid) begin
         illegal <= dec_nop;
      end
   end
`else
   logic unused_nop;
   assign unused_nop = dec_nop;
   assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Directed-vector bench for rv32i_exec_unit; expected values are hand-computed encodings/results.

module tb_rv32i_exec_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic        out_valid;
   logic [31:0] alu_result;
   logic [31:0] pc_imm;
   logic [31:0] jump_target;
   logic [3:0]  alu_sel;
   logic        reg_we;
   logic        mem_we;
   logic        mem_re;
   logic [1:0]  mem_size;
   logic        load_unsigned;
   logic [2:0]  wb_sel;
   logic [1:0]  pc_sel;
   logic        illegal;

   int vectors;
   int miscompares;

   rv32i_exec_unit #(.XLEN(32)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .instr(instr),
      .pc(pc),
      .rs1_data(rs1_data),
      .rs2_data(rs2_data),
      .imm(imm),
      .out_valid(out_valid),
      .alu_result(alu_result),
      .pc_imm(pc_imm),
      .jump_target(jump_target),
      .alu_sel(alu_sel),
      .reg_we(reg_we),
      .mem_we(mem_we),
      .mem_re(mem_re),
      .mem_size(mem_size),
      .load_unsigned(load_unsigned),
      .wb_sel(wb_sel),
      .pc_sel(pc_sel),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
      in_valid = v;
      instr    = ins;
      pc       = p;
      rs1_data = a;
      rs2_data = b;
      imm      = im;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clk         = 1'b0;
      rst         = 1'b1;

      // Reset beats a valid ADD presented at the same time.
      applyStimulus(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 32'h10);
      applyStimulus(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 32'h10);
      checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst alu_result", alu_result, 32'd0);
      checkOutput("rst pc_imm", pc_imm, 32'd0);
      checkOutput("rst jump_target", jump_target, 32'd0);
      checkOutput("rst ctrl", {16'd0, alu_sel, reg_we, mem_we, mem_re, mem_size, load_unsigned, wb_sel, pc_sel, illegal},
                  32'd0);
      rst = 1'b0;

      // add x3,x1,x2
      applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);
      checkOutput("add out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("add result", alu_result, 32'd12);
      checkOutput("add reg_we", {31'd0, reg_we}, 32'd1);
      checkOutput("add wb_sel", {29'd0, wb_sel}, 32'd0);
      checkOutput("add alu_sel", {28'd0, alu_sel}, 32'd0);

      // sub x3,x1,x2
      applyStimulus(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 32'h0);
      checkOutput("sub result", alu_result, 32'hFFFFFFFE);
      checkOutput("sub alu_sel", {28'd0, alu_sel}, 32'd1);

      // srai x3,x1,4
      applyStimulus(1'b1, 32'h4040D193, 32'h0, 32'h80000000, 32'd0, 32'h00000404);
      checkOutput("srai result", alu_result, 32'hF8000000);
      checkOutput("srai alu_sel", {28'd0, alu_sel}, 32'd7);

      // slt / sltu x3,x1,x2
      applyStimulus(1'b1, 32'h0020A1B3, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
      checkOutput("slt result", alu_result, 32'd1);
      applyStimulus(1'b1, 32'h0020B1B3, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
      checkOutput("sltu result", alu_result, 32'd0);

      // auipc x3,1
      applyStimulus(1'b1, 32'h00001197, 32'h100, 32'd0, 32'd0, 32'h1000);
      checkOutput("auipc pc_imm", pc_imm, 32'h1100);
      checkOutput("auipc wb_sel", {29'd0, wb_sel}, 32'd3);
      checkOutput("auipc reg_we", {31'd0, reg_we}, 32'd1);

      // jalr x1,4(x5)
      applyStimulus(1'b1, 32'h004280E7, 32'h200, 32'h203, 32'd0, 32'd4);
      checkOutput("jalr jump_target", jump_target, 32'h206);
      checkOutput("jalr pc_sel", {30'd0, pc_sel}, 32'd2);
      checkOutput("jalr wb_sel", {29'd0, wb_sel}, 32'd2);

      // blt x1,x2,+8 (taken) then bltu (not taken)
      applyStimulus(1'b1, 32'h0020C463, 32'h300, 32'hFFFFFFF0, 32'd1, 32'd8);
      checkOutput("blt pc_sel", {30'd0, pc_sel}, 32'd1);
      checkOutput("blt reg_we", {31'd0, reg_we}, 32'd0);
      checkOutput("blt pc_imm", pc_imm, 32'h308);
      checkOutput("blt result", alu_result, 32'hFFFFFFEF);
      applyStimulus(1'b1, 32'h0020E463, 32'h300, 32'hFFFFFFF0, 32'd1, 32'd8);
      checkOutput("bltu pc_sel", {30'd0, pc_sel}, 32'd0);
      checkOutput("bltu reg_we", {31'd0, reg_we}, 32'd0);

      // sw x2,4(x1)
      applyStimulus(1'b1, 32'h0020A223, 32'h0, 32'h80, 32'h55, 32'd4);
      checkOutput("sw addr", alu_result, 32'h84);
      checkOutput("sw mem_we/reg_we", {30'd0, mem_we, reg_we}, 32'd2);
      checkOutput("sw mem_size", {30'd0, mem_size}, 32'd2);

      // lhu x3,2(x1)
      applyStimulus(1'b1, 32'h0020D183, 32'h0, 32'h40, 32'd0, 32'd2);
      checkOutput("lhu addr", alu_result, 32'h42);
      checkOutput("lhu mem_re", {31'd0, mem_re}, 32'd1);
      checkOutput("lhu mem_size", {30'd0, mem_size}, 32'd1);
      checkOutput("lhu load_unsigned", {31'd0, load_unsigned}, 32'd1);
      checkOutput("lhu wb_sel", {29'd0, wb_sel}, 32'd1);

      // Bubble: outputs hold the LHU results.
      applyStimulus(1'b0, 32'h002081B3, 32'h0, 32'd1, 32'd1, 32'd1);
      checkOutput("hold out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("hold addr", alu_result, 32'h42);
      checkOutput("hold mem_re", {31'd0, mem_re}, 32'd1);
      checkOutput("hold wb_sel", {29'd0, wb_sel}, 32'd1);

      // Undecodable word becomes a NOP.
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'h0, 32'd3, 32'd0, 32'd4);
      checkOutput("nop ctrl", {24'd0, reg_we, mem_we, mem_re, wb_sel, pc_sel}, 32'd0);
      checkOutput("nop alu_sel", {28'd0, alu_sel}, 32'd0);
`ifdef EXEC_ILLEGAL_DET_EN
      checkOutput("nop illegal", {31'd0, illegal}, 32'd1);
      applyStimulus(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 32'd0);
      checkOutput("legal illegal", {31'd0, illegal}, 32'd0);
`else
      checkOutput("nop illegal", {31'd0, illegal}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
